// File: rtl/incoming_port_handler_pkg.sv
// Shared types and defaults for the router input port: widths, direction encodings
// and the XY dimension-order routing function.
package incoming_port_handler_pkg;

    localparam int NETWORK_ADDRESS_WIDTH    = 4;
    localparam int CACHE_BANK_ADDRESS_WIDTH = 2;
    localparam int DATA_WIDTH               = 8;
    localparam int COORD_MAX_W              = 16;

    typedef enum logic [2:0] {
        DIR_NORTH = 3'd0,
        DIR_SOUTH = 3'd1,
        DIR_EAST  = 3'd2,
        DIR_WEST  = 3'd3,
        DIR_LOCAL = 3'd4
    } direction_t;

    // X is resolved first, then Y; coordinates arrive zero-extended so compares stay unsigned.
    function automatic direction_t routeXY(
        input logic [COORD_MAX_W-1:0] dX,
        input logic [COORD_MAX_W-1:0] dY,
        input logic [COORD_MAX_W-1:0] lX,
        input logic [COORD_MAX_W-1:0] lY
    );
        if (dX > lX)      return DIR_EAST;
        else if (dX < lX) return DIR_WEST;
        else if (dY > lY) return DIR_SOUTH;
        else if (dY < lY) return DIR_NORTH;
        else              return DIR_LOCAL;
    endfunction

endpackage

// File: rtl/incoming_port_handler_fifo.sv
// Generic synchronous packet FIFO; the caller packs packet fields into one word and
// guarantees push is only asserted when there is room (or a pop on the same edge).
module packet_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           writeData,
    output logic [WIDTH-1:0]           readData,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPop;

    assign doPop    = pop && (count != '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign readData = mem[rdPtr];

    // Storage is cleared on reset so the head fields read back as zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wrPtr] <= writeData;
                wrPtr      <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (push && !doPop) begin
                count <= count + CNT_W'(1);
            end else if (doPop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/incoming_port_handler.sv
// Receiving end of one router link: buffers arriving packets, routes the head packet
// XY-first and raises one select toward the matching output arbiter or the local cache.
module incoming_port_handler
    import incoming_port_handler_pkg::*;
#(
    parameter int NET_AW  = NETWORK_ADDRESS_WIDTH,
    parameter int BANK_AW = CACHE_BANK_ADDRESS_WIDTH,
    parameter int DATA_W  = DATA_WIDTH,
    parameter int DEPTH   = 4,
    parameter int IN_DIR  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NET_AW-1:0]          localAddress,
    input  logic [NET_AW+BANK_AW-1:0]  destinationAddressIn,
    input  logic [NET_AW-1:0]          requesterAddressIn,
    input  logic                       readIn,
    input  logic                       writeIn,
    input  logic [DATA_W-1:0]          dataIn,
    output logic                       bufferFull,
    input  logic                       grant_NORTH,
    input  logic                       grant_SOUTH,
    input  logic                       grant_EAST,
    input  logic                       grant_WEST,
    input  logic                       grant_LOCAL,
    output logic                       selectBit_NORTH,
    output logic                       selectBit_SOUTH,
    output logic                       selectBit_EAST,
    output logic                       selectBit_WEST,
    output logic                       selectBit_LOCAL,
    output logic [NET_AW+BANK_AW-1:0]  destinationAddressOut,
    output logic [NET_AW-1:0]          requesterAddressOut,
    output logic                       readOut,
    output logic                       writeOut,
    output logic [DATA_W-1:0]          dataOut,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       overflowError,
    output logic                       malformedError,
    output logic                       uTurnError
);

    localparam int HALF  = NET_AW / 2;
    localparam int PKT_W = NET_AW + BANK_AW + NET_AW + 2 + DATA_W;

    logic [PKT_W-1:0]          pktIn;
    logic [PKT_W-1:0]          pktHead;
    logic [NET_AW+BANK_AW-1:0] headDest;
    logic [NET_AW-1:0]         headReq;
    logic                      headRead;
    logic                      headWrite;
    logic [DATA_W-1:0]         headData;
    logic [NET_AW-1:0]         headNode;
    logic                      fifoFull;
    logic                      fifoEmpty;
    logic                      packetValid;
    logic                      malformed;
    logic                      push;
    logic                      pop;
    direction_t                routeDir;
    logic [4:0]                selVec;
    logic [4:0]                grantVec;

    assign pktIn = {destinationAddressIn, requesterAddressIn, readIn, writeIn, dataIn};
    assign {headDest, headReq, headRead, headWrite, headData} = pktHead;
    assign headNode = headDest[NET_AW+BANK_AW-1 -: NET_AW];

    assign packetValid = readIn | writeIn;
    assign malformed   = readIn & writeIn;
    assign grantVec    = {grant_LOCAL, grant_WEST, grant_EAST, grant_SOUTH, grant_NORTH};
    assign pop         = |(selVec & grantVec);
    assign push        = packetValid && !malformed && (!fifoFull || pop);

    packet_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .writeData (pktIn),
        .readData  (pktHead),
        .full      (fifoFull),
        .empty     (fifoEmpty),
        .count     (occupancy)
    );

    assign routeDir = routeXY(COORD_MAX_W'(headNode[NET_AW-1 -: HALF]),
                              COORD_MAX_W'(headNode[HALF-1:0]),
                              COORD_MAX_W'(localAddress[NET_AW-1 -: HALF]),
                              COORD_MAX_W'(localAddress[HALF-1:0]));

    // Exactly one request for a non-empty buffer, none otherwise.
    always_comb begin
        selVec = '0;
        if (!fifoEmpty) begin
            selVec[routeDir] = 1'b1;
        end
    end

    assign {selectBit_LOCAL, selectBit_WEST, selectBit_EAST,
            selectBit_SOUTH, selectBit_NORTH} = selVec;

    assign bufferFull            = fifoFull;
    assign destinationAddressOut = headDest;
    assign requesterAddressOut   = headReq;
    assign dataOut               = headData;
    assign readOut               = headRead & !fifoEmpty;
    assign writeOut              = headWrite & !fifoEmpty;

    // Sticky error flags; a u-turn is only reported, the packet still goes out.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflowError  <= 1'b0;
            malformedError <= 1'b0;
            uTurnError     <= 1'b0;
        end else begin
            if (packetValid && !malformed && fifoFull && !pop) begin
                overflowError <= 1'b1;
            end
            if (malformed) begin
                malformedError <= 1'b1;
            end
            if (!fifoEmpty && (IN_DIR != 4) && (routeDir == IN_DIR[2:0])) begin
                uTurnError <= 1'b1;
            end
        end
    end

endmodule
